// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: 16-deep byte FIFO feeding an 8N1 serializer on tx.
// Define UART_PARITY_EN to insert an even-parity bit between the data and stop bits (8E1).
module uart_buffered_tx #(
    parameter int UART_BSP = 115200,
    parameter int CLK_FREQ = 50_000_000,
    parameter int FIFO_AW  = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [7:0]         data_in,
    input  logic               wr_en,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level,
    output logic               busy,
    output logic               tx
);
    localparam int BIT_CYC = CLK_FREQ / UART_BSP;
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int BW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    localparam logic [BW-1:0]      BAUD_LAST  = BW'(BIT_CYC - 1);
    localparam logic [BW-1:0]      BAUD_ONE   = BW'(1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [2:0]         state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic       push;
    logic       pop;
    logic       baud_last;
    logic [7:0] head;

    assign head      = mem_q[rd_ptr_q];
    assign baud_last = (baud_q == BAUD_LAST);
    // Full is judged on the pre-edge level, so a write is dropped even when a pop frees a slot.
    assign push      = wr_en && !full_q;
    assign pop       = !empty_q &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end
        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_last ? '0 : baud_q + BAUD_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d   = ST_START;
                    shift_d   = head;
                    bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
                    parity_d  = ^head;
`endif
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    // Chain straight into the next frame when a byte is waiting.
                    if (pop) begin
                        state_d   = ST_START;
                        shift_d   = head;
                        bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
                        parity_d  = ^head;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // The line follows the current state one clock later, keeping tx purely registered.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;
    assign busy  = (state_q != ST_IDLE);
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Scoreboard bench for uart_buffered_tx: a line monitor decodes frames from tx and each
// scenario task compares decoded bytes, timing and flags against its own expectations.
module tb_uart_buffered_tx;
    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BSP = 120_000;
    localparam int FIFO_AW  = 4;
    localparam int B        = CLK_FREQ / UART_BSP;   // 8 after truncation
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * B;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [7:0]       data_in = 8'h00;
    logic             wr_en = 1'b0;
    logic             full, empty, busy, tx;
    logic [FIFO_AW:0] level;

    uart_buffered_tx #(
        .UART_BSP(UART_BSP),
        .CLK_FREQ(CLK_FREQ),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int rst_cnt = 0;
    always @(negedge sys_rst_n) rst_cnt = rst_cnt + 1;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       par_q[$];
    int         frm_err = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    // Line monitor: samples mid-bit on falling clock edges; frames cut by reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        logic       p;
        logic       bad;
        int         t0;
        int         r0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && tx === 1'b0) begin
                t0 = cyc;
                r0 = rst_cnt;
                bad = 1'b0;
                b = 8'h00;
                p = 1'b0;
                repeat (B / 2) @(negedge sys_clk);
                if (tx !== 1'b0) bad = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge sys_clk);
                    b[i] = tx;
                end
`ifdef UART_PARITY_EN
                repeat (B) @(negedge sys_clk);
                p = tx;
                if (p !== ^b) bad = 1'b1;
`endif
                repeat (B) @(negedge sys_clk);
                if (tx !== 1'b1) bad = 1'b1;
                if (rst_cnt == r0) begin
                    if (bad) frm_err = frm_err + 1;
                    rx_q.push_back(b);
                    start_q.push_back(t0);
                    par_q.push_back(p);
                end
            end
        end
    end

    task automatic push_at(input int target, input logic [7:0] b, input bit accept);
        while (cyc < target - 1) @(negedge sys_clk);
        data_in = b;
        wr_en   = 1'b1;
        @(negedge sys_clk);
        wr_en   = 1'b0;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic wait_rx(input int n);
        int budget;
        budget = (n + 2) * FRAME + 100;
        while (rx_q.size() < n && budget > 0) begin
            @(negedge sys_clk);
            budget--;
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
        par_q.delete();
        frm_err = 0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        tests_run += 5;
        if (tx !== 1'b1)     begin tests_failed++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (busy !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (empty !== 1'b1)  begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty); end
        if (full !== 1'b0)   begin tests_failed++; $display("FAIL reset_full: got %b want 0", full); end
        if (level !== 5'd0)  begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        int n;
        logic [7:0] got, want;
        n = cyc + 1;
        push_at(n, 8'h55, 1'b1);
        tests_run += 2;
        if (empty !== 1'b0) begin tests_failed++; $display("FAIL single_empty_after_wr: got %b want 0", empty); end
        if (level !== 5'd1) begin tests_failed++; $display("FAIL single_level_after_wr: got %0d want 1", level); end
        @(negedge sys_clk);
        tests_run += 2;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_n1: got %b want 1", busy); end
        if (tx !== 1'b1)   begin tests_failed++; $display("FAIL single_tx_n1: got %b want 1", tx); end
        @(negedge sys_clk);
        tests_run++;
        if (tx !== 1'b0) begin tests_failed++; $display("FAIL single_tx_n2: got %b want 0", tx); end
        while (cyc < n + FRAME) @(negedge sys_clk);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_frame_end: got %b want 1", busy); end
        @(negedge sys_clk);
        tests_run += 2;
        if (busy !== 1'b0)  begin tests_failed++; $display("FAIL single_busy_after: got %b want 0", busy); end
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty_after: got %b want 1", empty); end
        wait_rx(1);
        tests_run++;
        if (rx_q.size() < 1) begin
            tests_failed++;
            $display("FAIL single_rx_count: got %0d frames want 1", rx_q.size());
        end else begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL single_byte: got %h want %h", got, want); end
            tests_run++;
            if (start_q[0] !== n + 2) begin
                tests_failed++;
                $display("FAIL single_latency: start at %0d want %0d", start_q[0], n + 2);
            end
        end
        tests_run++;
        if (frm_err !== 0) begin tests_failed++; $display("FAIL single_framing: got %0d errors want 0", frm_err); end
        $display("[TB] test_single done");
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] got, want;
        do_reset();
        n = cyc + 1;
        for (int i = 0; i < 16; i++) push_at(n + i, 8'(i), 1'b1);
        push_at(n + 16, 8'hAA, 1'b1);
        tests_run += 2;
        if (level !== 5'd16) begin tests_failed++; $display("FAIL b2b_level_full: got %0d want 16", level); end
        if (full !== 1'b1)   begin tests_failed++; $display("FAIL b2b_full: got %b want 1", full); end
        push_at(n + 17, 8'hBB, 1'b0);
        tests_run += 2;
        if (level !== 5'd16) begin tests_failed++; $display("FAIL b2b_drop_level: got %0d want 16", level); end
        if (full !== 1'b1)   begin tests_failed++; $display("FAIL b2b_drop_full: got %b want 1", full); end
        wait_rx(17);
        tests_run++;
        if (rx_q.size() != 17) begin
            tests_failed++;
            $display("FAIL b2b_rx_count: got %0d frames want 17", rx_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL b2b_byte: got %h want %h", got, want); end
        end
        for (int k = 1; k < start_q.size(); k++) begin
            tests_run++;
            if (start_q[k] - start_q[k-1] !== FRAME) begin
                tests_failed++;
                $display("FAIL b2b_gap: frame %0d spacing %0d want %0d", k, start_q[k] - start_q[k-1], FRAME);
            end
        end
        tests_run++;
        if (frm_err !== 0) begin tests_failed++; $display("FAIL b2b_framing: got %0d errors want 0", frm_err); end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_full_pop();
        int n, p, q;
        logic [7:0] got, want;
        do_reset();
        n = cyc + 1;
        for (int i = 0; i <= 16; i++) push_at(n + i, 8'h80 + 8'(i), 1'b1);
        tests_run += 2;
        if (level !== 5'd16) begin tests_failed++; $display("FAIL fullpop_level16: got %0d want 16", level); end
        if (full !== 1'b1)   begin tests_failed++; $display("FAIL fullpop_full: got %b want 1", full); end
        // First pop after the head frame lands at n+1+FRAME.
        p = n + 1 + FRAME;
        while (cyc < p - 1) @(negedge sys_clk);
        tests_run++;
        if (level !== 5'd16) begin tests_failed++; $display("FAIL fullpop_pre_level: got %0d want 16", level); end
        push_at(p, 8'hEE, 1'b0);
        tests_run += 2;
        if (level !== 5'd15) begin tests_failed++; $display("FAIL fullpop_drop_level: got %0d want 15", level); end
        if (full !== 1'b0)   begin tests_failed++; $display("FAIL fullpop_drop_full: got %b want 0", full); end
        q = n + 1 + 14 * FRAME;
        while (cyc < q - 1) @(negedge sys_clk);
        tests_run++;
        if (level !== 5'd3) begin tests_failed++; $display("FAIL fullpop_pre3: got %0d want 3", level); end
        push_at(q, 8'hE3, 1'b1);
        tests_run++;
        if (level !== 5'd3) begin tests_failed++; $display("FAIL fullpop_same3: got %0d want 3", level); end
        wait_rx(18);
        tests_run++;
        if (rx_q.size() != 18) begin
            tests_failed++;
            $display("FAIL fullpop_rx_count: got %0d frames want 18", rx_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL fullpop_byte: got %h want %h", got, want); end
        end
        $display("[TB] test_full_pop done");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        n = cyc + 1;
        push_at(n, 8'hC3, 1'b0);
        for (int i = 1; i <= 5; i++) push_at(n + i, 8'h10 + 8'(i), 1'b0);
        while (cyc < n + 1 + 4 * B) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        tests_run += 5;
        if (tx !== 1'b1)    begin tests_failed++; $display("FAIL midrst_tx: got %b want 1", tx); end
        if (busy !== 1'b0)  begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL midrst_empty: got %b want 1", empty); end
        if (level !== 5'd0) begin tests_failed++; $display("FAIL midrst_level: got %0d want 0", level); end
        if (full !== 1'b0)  begin tests_failed++; $display("FAIL midrst_full: got %b want 0", full); end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3 * FRAME) @(negedge sys_clk);
        tests_run += 3;
        if (rx_q.size() != 0) begin tests_failed++; $display("FAIL midrst_frames: got %0d frames want 0", rx_q.size()); end
        if (busy !== 1'b0)    begin tests_failed++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
        if (tx !== 1'b1)      begin tests_failed++; $display("FAIL midrst_tx_after: got %b want 1", tx); end
        $display("[TB] test_reset_mid_frame done");
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int n;
        do_reset();
        n = cyc + 1;
        push_at(n, 8'h07, 1'b1);
        push_at(n + 1, 8'h03, 1'b1);
        wait_rx(2);
        tests_run++;
        if (rx_q.size() != 2) begin
            tests_failed++;
            $display("FAIL parity_rx_count: got %0d frames want 2", rx_q.size());
        end else begin
            tests_run += 5;
            if (rx_q[0] !== 8'h07) begin tests_failed++; $display("FAIL parity_byte0: got %h want 07", rx_q[0]); end
            if (rx_q[1] !== 8'h03) begin tests_failed++; $display("FAIL parity_byte1: got %h want 03", rx_q[1]); end
            if (par_q[0] !== 1'b1) begin tests_failed++; $display("FAIL parity_bit0: got %b want 1", par_q[0]); end
            if (par_q[1] !== 1'b0) begin tests_failed++; $display("FAIL parity_bit1: got %b want 0", par_q[1]); end
            if (start_q[1] - start_q[0] !== 11 * B) begin
                tests_failed++;
                $display("FAIL parity_frame_len: got %0d want %0d", start_q[1] - start_q[0], 11 * B);
            end
        end
        $display("[TB] test_parity done");
    endtask
`endif

    task automatic test_stream();
        int guard;
        logic [7:0] got, want;
        do_reset();
        for (int v = 0; v < 256; v++) begin
            guard = 4 * FRAME;
            while (full === 1'b1 && guard > 0) begin
                @(negedge sys_clk);
                guard--;
            end
            push_at(cyc + 1, 8'(v), 1'b1);
        end
        wait_rx(256);
        tests_run++;
        if (rx_q.size() != 256) begin
            tests_failed++;
            $display("FAIL stream_rx_count: got %0d frames want 256", rx_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL stream_byte: got %h want %h", got, want); end
        end
        tests_run++;
        if (frm_err !== 0) begin tests_failed++; $display("FAIL stream_framing: got %0d errors want 0", frm_err); end
        $display("[TB] test_stream done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
